mux_rr_arb: RTL and testbench
=============================

# mux_rr_arb

Parametrised N-channel registered multiplexer with valid/ready handshakes, round-robin or fixed-select arbitration, and packet locking. It is the next generation of the datapath muxes in the MIPS core. It lets several sources, such as instruction fetch, data load/store and debug, share one downstream port (e.g. the memory interface) without corrupting multi-beat transfers. One output register stage decouples the downstream timing.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each data channel
- NUM_CH, 4, number of input channels (legal 2..16)
- SEL_W, $clog2(NUM_CH), localparam, channel index width

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = round-robin, 1 = fixed select
- fix_sel  input  SEL_W  channel granted when mode=1
- in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  input  NUM_CH  beat is last of packet (single-beat transfer: last=1)
- in_valid  input  NUM_CH  channel i offers a beat
- in_ready  output  NUM_CH  channel i beat accepted this cycle when valid&ready
- out_data  output  DATA_WIDTH  registered data
- out_last  output  1  registered last flag
- out_sel  output  SEL_W  index of source channel of current out beat
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts beat

## Operation
- can_load = !out_valid || out_ready; input transfer on channel g = in_valid[g] && in_ready[g].
- in_ready[i] = grant[i] && can_load; at most one bit of grant set; in_ready forced all-0 while rst_n=0.
- State IDLE (no packet open):
  - mode=0: grant first valid channel searching ptr+1, ptr+2, … mod NUM_CH; none valid -> no grant.
  - mode=1: grant fix_sel if in_valid[fix_sel]; fix_sel >= NUM_CH -> no grant.
  - transfer with in_last=0 -> LOCK, lock_ch <= g.
  - transfer with in_last=1 -> stay IDLE.
- State LOCK: grant only lock_ch (if valid); mode, fix_sel and other channels ignored; transfer with in_last=1 -> IDLE.
- ptr (round-robin pointer, SEL_W bits) <= g on every transfer with in_last=1, in either mode. Fairness is therefore per packet, not per beat.
- Output register on can_load: transfer -> out_data/out_last/out_sel <= selected channel, out_valid <= 1; no transfer -> out_valid <= 0, data/last/sel held.
- Reset values: out_valid 0, out_data 0, out_last 0, out_sel 0, state IDLE, lock_ch 0, ptr NUM_CH-1 (channel 0 wins first).
- Reset mid-packet: lock and buffered beat discarded immediately; upstream/downstream recovery is the sources' responsibility.

## Timing
- Latency: beat accepted at edge N appears on out_* from edge N (visible cycle N+1) until accepted.
- Full throughput: one beat per cycle when out_ready held 1.
- in_ready is combinational from in_valid, in_last-independent state, mode, fix_sel and out_ready. There is no combinational path from in_data to any output.
- out_valid=1 and out_ready=0 -> out_* stable, all in_ready 0.
- Grant/ptr/state update only on an accepted beat; a stalled grant may change arbitration winner only in IDLE while no beat is accepted.
- Simultaneous mode change and last beat: the new mode applies from the cycle after the transfer.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0; release -> first beat from channel 0, out_sel=0.
- Round-robin: NUM_CH=4, all channels valid with single-beat data 0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0..0xA3,0xA0.
- Packet lock: ch1 sends 3 beats (last on 3rd) while ch0/ch2 valid -> out_sel=1 for 3 consecutive beats, then ch2, then ch0.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_sel unchanged, in_ready=0; out_ready=1 -> next beat follows with no bubble.
- Fixed mode: mode=1, fix_sel=2, all valid -> only ch2 accepted. Set fix_sel=3 mid-packet on ch2 -> switch takes effect only after ch2's last beat. fix_sel=5 with NUM_CH=4 -> no grant.
- Reset mid-packet: assert rst_n during LOCK on ch3 -> out_valid=0 asynchronously. After release, arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_rr_arb.sv
// N-channel registered mux with valid/ready handshakes, round-robin or fixed
// arbitration, and packet locking so multi-beat transfers are never interleaved.
`timescale 1ns/1ps

module mux_rr_arb #(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_CH     = 4,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             fix_sel,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_last,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic [SEL_W-1:0]             out_sel,
  output logic                         out_valid,
  input  logic                         out_ready
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                  state;
  logic [SEL_W-1:0]        lock_ch;
  logic [SEL_W-1:0]        ptr;

  logic                    can_load;
  logic                    rr_hit;
  logic [SEL_W-1:0]        rr_ch;
  int                      rr_best;
  int                      rr_dist;
  logic                    fx_hit;
  logic                    lk_hit;
  logic                    gnt_hit;
  logic [SEL_W-1:0]        gnt_ch;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic                    gnt_last;
  logic                    xfer;

  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    last_p1;
  logic [SEL_W-1:0]        sel_p1;
  logic                    vld_p1;

  // Stage p0: arbitration and input select (combinational)
  assign can_load = !vld_p1 || out_ready;

  // Round-robin winner is the valid channel with the smallest distance past ptr.
  always_comb begin
    rr_hit  = 1'b0;
    rr_ch   = '0;
    rr_best = NUM_CH;
    rr_dist = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_dist = (i + 2 * NUM_CH - 1 - int'(ptr)) % NUM_CH;
      if (in_valid[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_hit  = 1'b1;
        rr_ch   = SEL_W'(i);
      end
    end
  end

  // An out-of-range fix_sel matches no channel and therefore grants nothing.
  always_comb begin
    fx_hit = 1'b0;
    lk_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fix_sel == SEL_W'(i)) fx_hit = in_valid[i];
      if (lock_ch == SEL_W'(i)) lk_hit = in_valid[i];
    end
  end

  always_comb begin
    if (state == ST_LOCK) begin
      gnt_hit = lk_hit;
      gnt_ch  = lock_ch;
    end else if (mode) begin
      gnt_hit = fx_hit;
      gnt_ch  = fix_sel;
    end else begin
      gnt_hit = rr_hit;
      gnt_ch  = rr_ch;
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_ch == SEL_W'(i)) begin
        in_ready[i] = gnt_hit && can_load && rst_n;
        gnt_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_last    = in_last[i];
      end
    end
  end

  assign xfer = gnt_hit && can_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lock_ch <= '0;
      ptr     <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      if (gnt_last) begin
        state <= ST_IDLE;
        ptr   <= gnt_ch;
      end else begin
        state   <= ST_LOCK;
        lock_ch <= gnt_ch;
      end
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
    end else if (can_load) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= gnt_data;
        last_p1 <= gnt_last;
        sel_p1  <= gnt_ch;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: directed scenarios plus randomized traffic against a
// packet-level reference model of the arbitration rules.
`timescale 1ns/1ps

module tb_mux_rr_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode;
  logic [1:0]   fix_sel;
  logic [127:0] in_data;
  logic [3:0]   in_last;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic         mode5;
  logic [2:0]   fix_sel5;
  logic [39:0]  in_data5;
  logic [4:0]   in_last5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic [7:0]   out_data5;
  logic         out_last5;
  logic [2:0]   out_sel5;
  logic         out_valid5;
  logic         out_ready5;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_locked;
  int          m_lock;
  int          m_ptr;
  bit          m_ov;
  logic [31:0] m_od;
  bit          m_ol;
  int          m_os;

  always #5 clk = ~clk;

  mux_rr_arb #(.DATA_WIDTH(32), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fix_sel(fix_sel),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_rr_arb #(.DATA_WIDTH(8), .NUM_CH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .fix_sel(fix_sel5),
    .in_data(in_data5), .in_last(in_last5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_last(out_last5), .out_sel(out_sel5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(32'hA0 + i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'(8'h50 + i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mode = 1'b0; fix_sel = 2'd0; in_valid = '0; in_last = '1; out_ready = 1'b1;
    mode5 = 1'b0; fix_sel5 = 3'd0; in_valid5 = '0; in_last5 = '1; out_ready5 = 1'b1;
    load_pattern();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int model_grant();
    if (m_locked) return in_valid[m_lock] ? m_lock : -1;
    if (mode) return in_valid[fix_sel] ? int'(fix_sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      int c = (m_ptr + k) % 4;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    mode = 1'b0; fix_sel = 2'd0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    mode5 = 1'b0; fix_sel5 = 3'd0; in_valid5 = '0; in_last5 = '1; out_ready5 = 1'b1;
    load_pattern();
    tick();
    tick();
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", out_data); else n_pass++;
    n_checks++; if (out_sel !== 2'd0) $display("FAIL reset_sel: got %0d expected 0", out_sel); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL release_ready: got %b expected 0001", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL release_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (out_sel !== 2'd0) $display("FAIL release_sel: got %0d expected 0", out_sel); else n_pass++;
    n_checks++; if (out_data !== 32'hA0) $display("FAIL release_data: got %h expected a0", out_data); else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++; if (out_sel !== 2'(n % 4)) $display("FAIL rr_sel%0d: got %0d expected %0d", n, out_sel, n % 4); else n_pass++;
      n_checks++; if (out_data !== 32'(32'hA0 + n % 4)) $display("FAIL rr_data%0d: got %h expected %h", n, out_data, 32'hA0 + n % 4); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL rr_valid%0d: got %b expected 1", n, out_valid); else n_pass++;
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    in_valid = 4'b0001;
    tick();
    in_valid = 4'b0111;
    in_last = 4'b1101;
    in_data[32 +: 32] = 32'hB1;
    tick();
    n_checks++; if (out_sel !== 2'd1 || out_data !== 32'hB1 || out_last !== 1'b0)
      $display("FAIL lock_beat1: got sel %0d data %h last %b expected 1 b1 0", out_sel, out_data, out_last); else n_pass++;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL lock_ready: got %b expected 0010", in_ready); else n_pass++;
    in_data[32 +: 32] = 32'hB2;
    tick();
    n_checks++; if (out_sel !== 2'd1 || out_data !== 32'hB2)
      $display("FAIL lock_beat2: got sel %0d data %h expected 1 b2", out_sel, out_data); else n_pass++;
    in_data[32 +: 32] = 32'hB3;
    in_last = 4'b1111;
    tick();
    n_checks++; if (out_sel !== 2'd1 || out_data !== 32'hB3 || out_last !== 1'b1)
      $display("FAIL lock_beat3: got sel %0d data %h last %b expected 1 b3 1", out_sel, out_data, out_last); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 2'd2 || out_data !== 32'hA2)
      $display("FAIL lock_next: got sel %0d data %h expected 2 a2", out_sel, out_data); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 2'd0 || out_data !== 32'hA0)
      $display("FAIL lock_after: got sel %0d data %h expected 0 a0", out_sel, out_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 4'hF;
    tick();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0)
        $display("FAIL stall_hold%0d: got v %b sel %0d data %h expected 1 0 a0", n, out_valid, out_sel, out_data); else n_pass++;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL stall_ready%0d: got %b expected 0000", n, in_ready); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL unstall_ready: got %b expected 0010", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'hA1)
      $display("FAIL unstall_beat1: got v %b sel %0d data %h expected 1 1 a1", out_valid, out_sel, out_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2)
      $display("FAIL unstall_beat2: got v %b sel %0d expected 1 2", out_valid, out_sel); else n_pass++;
  endtask

  task automatic test_fixed_mode();
    do_reset();
    mode = 1'b1;
    fix_sel = 2'd2;
    in_valid = 4'hF;
    #1;
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL fix_ready: got %b expected 0100", in_ready); else n_pass++;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++; if (out_sel !== 2'd2 || out_data !== 32'hA2)
        $display("FAIL fix_sel%0d: got sel %0d data %h expected 2 a2", n, out_sel, out_data); else n_pass++;
    end
    in_last = 4'b1011;
    tick();
    fix_sel = 2'd3;
    #1;
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL fix_locked_ready: got %b expected 0100", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 2'd2 || out_last !== 1'b0)
      $display("FAIL fix_locked_beat: got sel %0d last %b expected 2 0", out_sel, out_last); else n_pass++;
    in_last = 4'b1111;
    tick();
    n_checks++; if (out_sel !== 2'd2 || out_last !== 1'b1)
      $display("FAIL fix_last_beat: got sel %0d last %b expected 2 1", out_sel, out_last); else n_pass++;
    #1;
    n_checks++; if (in_ready !== 4'b1000) $display("FAIL fix_switch_ready: got %b expected 1000", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 2'd3 || out_data !== 32'hA3)
      $display("FAIL fix_switch_beat: got sel %0d data %h expected 3 a3", out_sel, out_data); else n_pass++;
  endtask

  task automatic test_fix_range();
    do_reset();
    mode5 = 1'b1;
    in_valid5 = 5'b11111;
    for (int fs = 5; fs < 8; fs++) begin
      fix_sel5 = 3'(fs);
      #1;
      n_checks++; if (in_ready5 !== 5'b00000) $display("FAIL range_ready%0d: got %b expected 00000", fs, in_ready5); else n_pass++;
      tick();
      n_checks++; if (out_valid5 !== 1'b0) $display("FAIL range_valid%0d: got %b expected 0", fs, out_valid5); else n_pass++;
    end
    fix_sel5 = 3'd4;
    #1;
    n_checks++; if (in_ready5 !== 5'b10000) $display("FAIL range_top_ready: got %b expected 10000", in_ready5); else n_pass++;
    tick();
    n_checks++; if (out_valid5 !== 1'b1 || out_sel5 !== 3'd4 || out_data5 !== 8'h54)
      $display("FAIL range_top_beat: got v %b sel %0d data %h expected 1 4 54", out_valid5, out_sel5, out_data5); else n_pass++;
    mode5 = 1'b0;
    tick();
    n_checks++; if (out_sel5 !== 3'd0) $display("FAIL wrap5_sel0: got %0d expected 0", out_sel5); else n_pass++;
    tick();
    n_checks++; if (out_sel5 !== 3'd1) $display("FAIL wrap5_sel1: got %0d expected 1", out_sel5); else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_valid = 4'b1000;
    in_last = 4'b0000;
    tick();
    n_checks++; if (out_sel !== 2'd3 || out_valid !== 1'b1)
      $display("FAIL midrst_first: got sel %0d v %b expected 3 1", out_sel, out_valid); else n_pass++;
    in_valid = 4'hF;
    tick();
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_async_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL midrst_ready: got %b expected 0000", in_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    in_last = 4'hF;
    #1;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL midrst_restart_ready: got %b expected 0001", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 2'd0 || out_valid !== 1'b1)
      $display("FAIL midrst_restart_beat: got sel %0d v %b expected 0 1", out_sel, out_valid); else n_pass++;
  endtask

  task automatic test_random();
    int g;
    bit can;
    logic [3:0] exp_rdy;
    do_reset();
    m_locked = 0; m_lock = 0; m_ptr = 3; m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    for (int n = 0; n < 3000; n++) begin
      in_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        in_last[i] = ($urandom_range(0, 9) < 4);
        in_data[i*32 +: 32] = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      fix_sel = 2'($urandom);
      #3;
      g = model_grant();
      can = !m_ov || out_ready;
      exp_rdy = (g >= 0 && can) ? 4'(1 << g) : 4'b0000;
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL rand_ready@%0d: got %b expected %b", n, in_ready, exp_rdy); else n_pass++;
      @(posedge clk);
      if (can) begin
        if (g >= 0) begin
          m_ov = 1; m_od = in_data[g*32 +: 32]; m_ol = in_last[g]; m_os = g;
          if (in_last[g]) begin m_locked = 0; m_ptr = g; end
          else begin m_locked = 1; m_lock = g; end
        end else begin
          m_ov = 0;
        end
      end
      #1;
      n_checks++; if (out_valid !== m_ov || out_data !== m_od || out_last !== m_ol || out_sel !== 2'(m_os))
        $display("FAIL rand_out@%0d: got v %b d %h l %b s %0d expected v %b d %h l %b s %0d",
                 n, out_valid, out_data, out_last, out_sel, m_ov, m_od, m_ol, m_os);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_back_to_back();
    test_fixed_mode();
    test_fix_range();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
